simon_says_seq: RTL and testbench

//  Parametrised Simon-says game core: replays a growing pseudo-random sequence on NBTN
//  one-hot LEDs, then checks the player's button presses against it. Extends the 2-button

---
 rtl/simon_says_seq.sv | 146 ++++++++++++++
 tb/tb_simon_says_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/simon_says_seq.sv
// simon_says_seq: Simon-says game core, NBTN buttons/LEDs, LFSR sequence replay and press checking.
// Optional input timeout enabled by defining SIMON_TIMEOUT_EN.
module simon_says_seq #(
  parameter int NBTN     = 4,
  parameter int MAX_LEN  = 15,
  parameter int CNT_W    = 6,
  parameter int SHOW_CYC = 4,
  parameter int GAP_CYC  = 2,
  parameter int TMO_CYC  = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [NBTN-1:0]  knapp,
  output logic [NBTN-1:0]  show_out,
  output logic             correct_out,
  output logic             fail_out,
  output logic             win_out,
  output logic [CNT_W-1:0] count_out,
  output logic             busy_out
);
  localparam int SW = $clog2(NBTN);
  localparam int TW = $clog2(SHOW_CYC + GAP_CYC + 1);
  typedef enum logic [2:0] {IDLE, SHOW, INPUT, FAIL, WIN} state_t;
  state_t state;
  logic [NBTN-1:0] k_m, k_s, k_q, want;
  logic [15:0] free_lfsr, seed, replay;
  logic [CNT_W-1:0] len, idx, pos;
  logic [TW-1:0] t;
  logic lit, press, tmo_hit;
  if (MAX_LEN < 1 || MAX_LEN > (2 ** CNT_W) - 1 || SHOW_CYC < 1 || GAP_CYC < 1 || TMO_CYC < 1) begin : g_bad_cfg
    $error("simon_says_seq: illegal parameter combination");
  end
  function automatic logic [15:0] step(input logic [15:0] r);
    return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
  endfunction
  function automatic logic [NBTN-1:0] sym(input logic [15:0] r);
    return NBTN'(1) << r[SW-1:0];
  endfunction
  assign press = (k_q == '0) && (k_s != '0);
  assign want = sym(replay);
`ifdef SIMON_TIMEOUT_EN
  localparam int OW = $clog2(TMO_CYC + 1);
  logic [OW-1:0] tmo;
  assign tmo_hit = (tmo == OW'(TMO_CYC - 1));
  // Timer runs only while waiting in INPUT; any press restarts the wait.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo <= '0;
    else if (ena) tmo <= (state != INPUT || press) ? '0 : tmo + 1'b1;
`else
  assign tmo_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k_m         <= '0;
      k_s         <= '0;
      k_q         <= '0;
      free_lfsr   <= 16'hACE1;
      seed        <= '0;
      replay      <= '0;
      len         <= '0;
      idx         <= '0;
      pos         <= '0;
      t           <= '0;
      lit         <= 1'b0;
      show_out    <= '0;
      correct_out <= 1'b0;
      fail_out    <= 1'b0;
      win_out     <= 1'b0;
      count_out   <= '0;
      busy_out    <= 1'b0;
    end else if (ena) begin
      k_m         <= knapp;
      k_s         <= k_m;
      k_q         <= k_s;
      free_lfsr   <= step(free_lfsr);
      correct_out <= 1'b0;
      case (state)
        IDLE, FAIL, WIN: if (press) begin
          seed      <= free_lfsr;
          replay    <= free_lfsr;
          len       <= CNT_W'(1);
          count_out <= '0;
          fail_out  <= 1'b0;
          win_out   <= 1'b0;
          pos       <= '0;
          t         <= '0;
          lit       <= 1'b1;
          show_out  <= sym(free_lfsr);
          busy_out  <= 1'b1;
          state     <= SHOW;
        end
        SHOW: if (lit) begin
          if (t == TW'(SHOW_CYC - 1)) begin
            lit      <= 1'b0;
            t        <= '0;
            show_out <= '0;
          end else t <= t + 1'b1;
        end else if (t == TW'(GAP_CYC - 1)) begin
          t <= '0;
          if (pos == len - 1'b1) begin
            replay   <= seed;
            idx      <= '0;
            busy_out <= 1'b0;
            state    <= INPUT;
          end else begin
            replay   <= step(replay);
            pos      <= pos + 1'b1;
            lit      <= 1'b1;
            show_out <= sym(step(replay));
          end
        end else t <= t + 1'b1;
        INPUT: if (press) begin
          if (k_s != want) begin
            fail_out <= 1'b1;
            state    <= FAIL;
          end else if (idx + 1'b1 == len) begin
            correct_out <= 1'b1;
            count_out   <= len;
            if (len == CNT_W'(MAX_LEN)) begin
              win_out <= 1'b1;
              state   <= WIN;
            end else begin
              len      <= len + 1'b1;
              replay   <= seed;
              pos      <= '0;
              t        <= '0;
              lit      <= 1'b1;
              show_out <= sym(seed);
              busy_out <= 1'b1;
              state    <= SHOW;
            end
          end else begin
            replay <= step(replay);
            idx    <= idx + 1'b1;
          end
        end else if (tmo_hit) begin
          fail_out <= 1'b1;
          state    <= FAIL;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_simon_says_seq.sv
// tb_simon_says_seq: directed self-checking bench for simon_says_seq (NBTN=4, MAX_LEN=3, TMO_CYC=20).
module tb_simon_says_seq;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [3:0] knapp = '0;
  logic [3:0] show_out;
  logic correct_out, fail_out, win_out, busy_out;
  logic [5:0] count_out;
  logic [15:0] m, seed;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  simon_says_seq #(.NBTN(4), .MAX_LEN(3), .CNT_W(6), .SHOW_CYC(4), .GAP_CYC(2), .TMO_CYC(20)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .knapp(knapp), .show_out(show_out),
    .correct_out(correct_out), .fail_out(fail_out), .win_out(win_out),
    .count_out(count_out), .busy_out(busy_out)
  );
  function automatic logic [15:0] lfsr_next(input logic [15:0] r);
    return {r[14:0], ^(r & 16'hB400)};
  endfunction
  function automatic logic [15:0] adv(input logic [15:0] r, input int n);
    logic [15:0] x = r;
    for (int i = 0; i < n; i++) x = lfsr_next(x);
    return x;
  endfunction
  function automatic logic [3:0] oh(input logic [15:0] r);
    return 4'b0001 << r[1:0];
  endfunction
  // Reference copy of the free-running LFSR, reset and gated exactly like the design's.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m <= 16'hACE1;
    else if (ena) m <= lfsr_next(m);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic outs_zero(input string tag);
    chk({tag, "_show"}, show_out, 0);
    chk({tag, "_corr"}, correct_out, 0);
    chk({tag, "_fail"}, fail_out, 0);
    chk({tag, "_win"}, win_out, 0);
    chk({tag, "_count"}, count_out, 0);
    chk({tag, "_busy"}, busy_out, 0);
  endtask
  task automatic start_game(input logic [3:0] v);
    logic [15:0] sm;
    int k = 0;
    knapp = v;
    do begin
      sm = m;
      tick;
      k++;
    end while (!busy_out && k < 10);
    chk("start_busy", busy_out, 1);
    chk("start_latency", k, 3);
    seed = sm;
    knapp = '0;
  endtask
  task automatic watch(input int len);
    int n, g;
    for (int s = 0; s < len; s++) begin
      n = 0;
      while (show_out != 0 && n < 20) begin
        if (n == 0) chk("sym", show_out, oh(adv(seed, s)));
        if (s == 0 && n == 1) chk("corr_pulse", correct_out, 0);
        n++;
        tick;
      end
      chk("lit_len", n, 4);
      g = 0;
      while (show_out == 0 && busy_out && g < 20) begin
        g++;
        tick;
      end
      chk("gap_len", g, 2);
    end
    chk("busy_end", busy_out, 0);
  endtask
  task automatic play(input int len);
    for (int s = 0; s < len; s++) begin
      knapp = oh(adv(seed, s));
      repeat (3) tick;
      if (s == len - 1) begin
        chk("correct", correct_out, 1);
        chk("count", count_out, len);
      end else chk("no_correct", correct_out, 0);
      knapp = '0;
      if (s < len - 1) repeat (3) tick;
    end
  endtask
  initial begin
    int k;
    #1;
    outs_zero("rst");
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    outs_zero("idle");
    start_game(4'b0001);
    chk("new_count", count_out, 0);
    watch(1);
    play(1);
    chk("round2_busy", busy_out, 1);
    watch(2);
    knapp = 4'b0011;
    repeat (3) tick;
    chk("bad_fail", fail_out, 1);
    chk("bad_count", count_out, 1);
    knapp = '0;
    repeat (3) tick;
    chk("fail_hold", fail_out, 1);
    chk("fail_idle", busy_out, 0);
    start_game(4'b0100);
    chk("restart_fail", fail_out, 0);
    chk("restart_count", count_out, 0);
    watch(1);
    knapp = oh(seed);
    ena = 1'b0;
    repeat (6) tick;
    chk("ena_corr", correct_out, 0);
    chk("ena_count", count_out, 0);
    knapp = '0;
    ena = 1'b1;
    repeat (3) tick;
    play(1);
    watch(2);
    play(2);
    watch(3);
    play(3);
    chk("win", win_out, 1);
    chk("win_busy", busy_out, 0);
    repeat (10) tick;
    chk("win_hold", win_out, 1);
    chk("win_noshow", busy_out, 0);
    start_game(4'b0010);
    chk("rewin_win", win_out, 0);
    chk("rewin_count", count_out, 0);
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    outs_zero("midrst");
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    outs_zero("postrst");
    start_game(4'b0001);
    watch(1);
`ifdef SIMON_TIMEOUT_EN
    k = 0;
    while (!fail_out && k < 100) begin
      tick;
      k++;
    end
    chk("tmo_cycles", k, 20);
    start_game(4'b0001);
    watch(1);
    repeat (5) tick;
    ena = 1'b0;
    repeat (10) tick;
    ena = 1'b1;
    k = 15;
    while (!fail_out && k < 100) begin
      tick;
      k++;
    end
    chk("tmo_ena_cycles", k, 30);
`else
    k = 0;
    repeat (50) begin
      tick;
      k++;
    end
    chk("no_tmo_fail", fail_out, 0);
    chk("no_tmo_busy", busy_out, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
